// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI mode-0 responder, MSB first. The external spi_clk,
//                spi_cs_n and MOSI_in are oversampled in the clk domain.
//                Received words are handed to the CPU side on rx_data /
//                rx_valid. A single-entry holding buffer (tx_data / tx_valid /
//                tx_ready) supplies the words that are serialised onto
//                MISO_out.
//  Ports       : clk          system clock, >= 4x spi_clk
//                rst          asynchronous reset, active low
//                tx_data/tx_valid/tx_ready   word to return to the master
//                rx_data/rx_valid            last complete word received
//                tx_underrun  pulse: a word started with an empty buffer
//                spi_clk/spi_cs_n/MOSI_in    SPI pins from the master
//                MISO_out/MISO_oe            SPI data pin to the master
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave #(
    parameter int W_Data    = 32,
    parameter int W_Counter = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_Data-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [W_Data-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              MOSI_in,
    output logic              MISO_out,
    output logic              MISO_oe
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [W_Counter-1:0] CNT_TOP = W_Counter'(W_Data - 1);

    // Synchronisers: index 0 is the first stage, index 1 the synchronised
    // value, index 2 (spi_clk / cs_n only) the previous value for edges.
    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [2:0]           cs_sync_q,   cs_sync_d;
    logic [1:0]           mosi_sync_q, mosi_sync_d;

    logic [1:0]           state_q,     state_d;
    logic [W_Counter-1:0] cnt_q,       cnt_d;
    logic [W_Data-1:0]    tx_shift_q,  tx_shift_d;
    logic [W_Data-1:0]    rx_shift_q,  rx_shift_d;
    logic [W_Data-1:0]    rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 underrun_q,  underrun_d;
    logic                 oe_q,        oe_d;
    logic [W_Data-1:0]    buf_q,       buf_d;
    logic                 buf_full_q,  buf_full_d;
    logic                 seen_rise_q, seen_rise_d;

    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 cs_fall;
    logic                 cs_rise;
    logic                 start_word;
    logic [W_Data-1:0]    rx_next;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
    assign rx_next   = {rx_shift_q[W_Data-2:0], mosi_sync_q[1]};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_clk};
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[0], MOSI_in};

        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        oe_d        = oe_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        seen_rise_d = seen_rise_q;
        start_word  = 1'b0;

        // Deselect wins over everything; a cs_n fall masks any spi_clk edge
        // detected in the same cycle.
        if (cs_rise) begin
            state_d    = ST_IDLE;
            oe_d       = 1'b0;
            tx_shift_d = '0;
        end else if (cs_fall) begin
            start_word = 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_d  = rx_next;
                        seen_rise_d = 1'b1;
                        if (cnt_q == '0) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            state_d    = ST_GAP;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end else if (sclk_fall && seen_rise_q) begin
                        // The first bit is already on MISO from word start,
                        // so only falls that follow a sampling rise advance.
                        tx_shift_d = {tx_shift_q[W_Data-2:0], 1'b0};
                    end
                end
                ST_GAP: begin
                    if (sclk_fall) begin
                        start_word = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (start_word) begin
            tx_shift_d  = buf_full_q ? buf_q : '0;
            underrun_d  = ~buf_full_q;
            buf_full_d  = 1'b0;
            cnt_d       = CNT_TOP;
            state_d     = ST_SHIFT;
            oe_d        = 1'b1;
            seen_rise_d = 1'b0;
        end

        // Applied after consumption so that a load coinciding with an
        // underrun start is kept for the following word.
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_TOP;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            oe_q        <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            seen_rise_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            oe_q        <= oe_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            seen_rise_q <= seen_rise_d;
        end
    end

    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign MISO_out    = tx_shift_q[W_Data-1];
    assign MISO_oe     = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Self-checking bench for spi_slave. A mode-0 master model
//                drives the SPI pins; expected MISO words, received words and
//                underrun counts come from a word-level model of the holding
//                buffer and are compared by independent monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        tx_underrun;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        MOSI_in = 1'b0;
    logic        MISO_out;
    logic        MISO_oe;

    int checks = 0;
    int errors = 0;

    // Word-level reference: the holding buffer is a queue of loaded words;
    // each word start takes the oldest one, or 0 with an underrun.
    logic [31:0] model_buf[$];
    logic [31:0] miso_exp[$];
    logic [31:0] rx_exp[$];
    int          und_exp  = 0;
    int          und_seen = 0;

    logic [31:0] mw[4];
    logic [31:0] rf_val[4];
    bit          rf_en[4];

    spi_slave #(.W_Data(32), .W_Counter(5)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .MOSI_in(MOSI_in),
        .MISO_out(MISO_out), .MISO_oe(MISO_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void start_word();
        if (model_buf.size() > 0) begin
            miso_exp.push_back(model_buf.pop_front());
        end else begin
            miso_exp.push_back(32'h0);
            und_exp++;
        end
    endfunction

    // MISO monitor: master samples on each spi_clk rising edge while selected.
    logic [31:0] macc = '0;
    int          mcnt = 0;
    always @(posedge spi_clk or posedge spi_cs_n or negedge rst) begin
        if (spi_cs_n || !rst) begin
            mcnt = 0;
        end else begin
            chk("miso_oe_during_word", {31'b0, MISO_oe}, 32'd1);
            macc = {macc[30:0], MISO_out};
            mcnt++;
            if (mcnt == 32) begin
                mcnt = 0;
                if (miso_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_word: got %h but no word expected", macc);
                end else begin
                    chk("miso_word", macc, miso_exp.pop_front());
                end
            end
        end
    end

    // CPU-side monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_word: got %h but no word expected", rx_data);
                end else begin
                    chk("rx_word", rx_data, rx_exp.pop_front());
                end
            end
            if (tx_underrun) und_seen++;
        end
    end

    task automatic load(input logic [31:0] v);
        int t = 0;
        @(negedge clk);
        while (!tx_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: tx_ready=%0d required 1", tx_ready);
        end else begin
            tx_data  = v;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            model_buf.push_back(v);
            chk("tx_ready_after_load", {31'b0, tx_ready}, 32'd0);
        end
    endtask

    // mode 0: plain start; 1: check tx_ready around consumption;
    // 2: present sl_val on tx_valid in the cs_n-fall detection cycle.
    // The final word ends with spi_clk held high until cs_n rises, so no
    // trailing fall is seen as a back-to-back word start.
    task automatic xfer(input int nw, input int abort_bits, input int mode,
                        input logic [31:0] sl_val);
        int          nb;
        bit          last;
        logic [31:0] dropped;
        @(negedge clk);
        spi_cs_n = 1'b0;
        start_word();
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (mode == 1) chk("tx_ready_before_consume", {31'b0, tx_ready}, 32'd0);
        if (mode == 2) begin
            chk("tx_ready_same_cycle", {31'b0, tx_ready}, 32'd1);
            tx_data  = sl_val;
            tx_valid = 1'b1;
        end
        @(negedge clk);
        if (mode == 1) chk("tx_ready_after_consume", {31'b0, tx_ready}, 32'd1);
        if (mode == 2) begin
            tx_valid = 1'b0;
            model_buf.push_back(sl_val);
        end
        repeat (6) @(negedge clk);
        nb = (abort_bits != 0) ? abort_bits : 32;
        for (int w = 0; w < nw; w++) begin
            if (abort_bits == 0) rx_exp.push_back(mw[w]);
            for (int b = 0; b < nb; b++) begin
                last    = (w == nw - 1) && (b == nb - 1);
                MOSI_in = mw[w][31 - b];
                repeat (4) @(negedge clk);
                spi_clk = 1'b1;
                repeat (4) @(negedge clk);
                if (!last) begin
                    spi_clk = 1'b0;
                    if (b == 31) start_word();
                    if (rf_en[w] && b == 8) load(rf_val[w]);
                end
            end
        end
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
        repeat (8) @(negedge clk);
        if (abort_bits != 0) dropped = miso_exp.pop_back();
        chk("underrun_count", und_seen, und_exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] prev;
        int          nw;

        // Reset state.
        #2 rst = 1'b0;
        #1;
        chk("reset_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("reset_miso_oe", {31'b0, MISO_oe}, 32'd0);
        chk("reset_miso_out", {31'b0, MISO_out}, 32'd0);
        chk("reset_underrun", {31'b0, tx_underrun}, 32'd0);
        chk("reset_rx_data", rx_data, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) rf_en[i] = 1'b0;

        // Basic transfer.
        load(32'hA5A50F0F);
        mw[0] = 32'h12345678;
        xfer(1, 0, 1, 32'h0);
        chk("basic_rx_data", rx_data, 32'h12345678);

        // Reset in the middle of a word.
        load(32'hCAFEF00D);
        @(negedge clk);
        spi_cs_n = 1'b0;
        start_word();
        repeat (8) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            MOSI_in = b[0];
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk);
            spi_clk = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("midreset_tx_ready", {31'b0, tx_ready}, 32'd1);
        chk("midreset_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("midreset_miso_oe", {31'b0, MISO_oe}, 32'd0);
        chk("midreset_rx_data", rx_data, 32'h0);
        prev = miso_exp.pop_back();
        model_buf.delete();
        @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Underrun: nothing loaded.
        mw[0] = 32'hDEADBEEF;
        xfer(1, 0, 0, 32'h0);
        chk("underrun_rx_data", rx_data, 32'hDEADBEEF);

        // Back-to-back with refill during word 1.
        load(32'h11111111);
        mw[0] = 32'h0F1E2D3C;
        mw[1] = 32'hA1B2C3D4;
        rf_en[0] = 1'b1;
        rf_val[0] = 32'h22222222;
        xfer(2, 0, 0, 32'h0);
        rf_en[0] = 1'b0;

        // Abort after 13 bits, then a full transfer.
        prev = rx_data;
        load(32'h5A5A5A5A);
        mw[0] = 32'hFFFF0000;
        xfer(1, 13, 0, 32'h0);
        chk("abort_rx_data_kept", rx_data, prev);
        chk("abort_miso_oe", {31'b0, MISO_oe}, 32'd0);
        load(32'h3C3C3C3C);
        mw[0] = 32'h87654321;
        xfer(1, 0, 0, 32'h0);
        chk("after_abort_rx_data", rx_data, 32'h87654321);

        // Load in the same cycle as the cs_n-fall detection.
        mw[0] = 32'h13579BDF;
        mw[1] = 32'h2468ACE0;
        xfer(2, 0, 2, 32'h600DCAFE);

        // Randomised transfers.
        for (int it = 0; it < 6; it++) begin
            nw = $urandom_range(1, 3);
            for (int w = 0; w < 4; w++) begin
                mw[w]     = $urandom;
                rf_val[w] = $urandom;
                rf_en[w]  = (w < nw - 1) && ($urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 1) == 1) load($urandom);
            xfer(nw, 0, 0, 32'h0);
        end

        repeat (10) @(negedge clk);
        chk("miso_queue_empty", miso_exp.size(), 32'd0);
        chk("rx_queue_empty", rx_exp.size(), 32'd0);
        chk("final_underrun_count", und_seen, und_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (responder) end of the CPU SPI link, SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- Oversamples the external spi_clk, spi_cs_n and MOSI_in in the system clock domain.
- Assembles received words for the CPU side and serialises CPU-supplied words onto MISO_out.
- Sits between the pad/bus pins and the CPU-side load/store interface.

Parameters:
- W_Data, 32 (`W_CPU): word width, in bits, for the shift registers and data ports.
- W_Counter, 5: bit-index counter width; must satisfy 2^W_Counter >= W_Data.

Ports:
- clk  input  1  system clock; must run at least 4x the spi_clk frequency.
- rst  input  1  asynchronous, active-low reset (asserted at 0).
- tx_data  input  W_Data  word to return to the master.
- tx_valid  input  1  tx_data is valid; a transfer occurs when tx_valid && tx_ready.
- tx_ready  output  1  transmit holding buffer is empty.
- rx_data  output  W_Data  last complete word received.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- tx_underrun  output  1  one-cycle pulse when a word starts with an empty holding buffer.
- spi_clk  input  1  SPI clock from the master; asynchronous to clk.
- spi_cs_n  input  1  chip select, active-low; asynchronous to clk.
- MOSI_in  input  1  serial data from the master.
- MISO_out  output  1  serial data to the master.
- MISO_oe  output  1  tri-state enable for MISO_out; 1 while selected.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchroniser state: spi_clk 0, spi_cs_n 1, MOSI_in 0.
  - holding buffer empty, tx_ready=1.
  - rx_data=0, rx_valid=0, tx_underrun=0, MISO_out=0, MISO_oe=0.
  - bit counter = W_Data-1, state IDLE.
- Synchronisation:
  - spi_clk, spi_cs_n and MOSI_in each pass through 2 flops.
  - A third flop on spi_clk and spi_cs_n provides edge detection.
  - All SPI events below refer to these synchronised edges: 2-3 clk after the pin edge.
- Holding buffer:
  - When tx_valid && tx_ready: capture tx_data; tx_ready=0 from the next cycle.
  - The buffer is consumed at word start; tx_ready=1 from the cycle after consumption.
- States:
  - IDLE: spi_cs_n high.
  - SHIFT: selected, transferring bits.
  - GAP: last bit of a word sampled, waiting for the next falling spi_clk edge.
- IDLE -> SHIFT on cs_n falling edge. In that cycle:
  - load the tx shift register from the buffer; if the buffer is empty, load 0 and pulse tx_underrun.
  - bit counter = W_Data-1.
  - MISO_out = MSB of the loaded word; MISO_oe=1.
- SHIFT, spi_clk rising edge:
  - rx shift register <= {rx shift[W_Data-2:0], synchronised MOSI}.
  - If bit counter == 0: next cycle rx_data = assembled word and rx_valid=1 for exactly 1 cycle; go to GAP.
  - Otherwise decrement the bit counter.
- SHIFT, spi_clk falling edge:
  - shift the tx register left by 1; MISO_out = new MSB.
  - No falling-edge shift occurs before the first rising edge of a word.
- GAP, spi_clk falling edge (back-to-back word):
  - reload the tx register from the buffer (or 0 with a tx_underrun pulse).
  - bit counter = W_Data-1; MISO_out = MSB; go to SHIFT.
- cs_n rising edge in any state:
  - go to IDLE; MISO_oe=0, MISO_out=0.
  - Partial rx bits are discarded, with no rx_valid.
  - A partially sent tx word is lost; the buffer is not restored.
- Simultaneous consumption and tx_valid with an empty buffer: the word starts with 0 (underrun) and the new tx_data is stored for the next word.
- rx_data holds its value until the next complete word. There is no receive backpressure; the consumer must take rx_data within W_Data spi_clk periods.
- cs_n falling and a spi_clk edge detected in the same cycle: the cs_n event is handled first; the spi_clk edge is ignored. The master must respect a setup time of at least 4 clk.
- rst asserted mid-transfer: immediate return to the reset values; the transfer is abandoned.

Test Plan:
- Reset: drive rst=0 mid-word, then rst=1 -> tx_ready=1, rx_valid=0, MISO_oe=0, rx_data=0 immediately.
- Basic transfer:
  - stimulus: load tx_data 0xA5A50F0F; master sends 0x12345678 with spi_clk = clk/8.
  - required: MISO bit stream equals 0xA5A50F0F MSB first; rx_data=0x12345678 with a single rx_valid pulse; tx_ready returns to 1 one cycle after cs_n falls.
- Underrun: select with no tx loaded -> tx_underrun pulse; MISO all 0s; rx still correct (0xDEADBEEF received).
- Back-to-back:
  - stimulus: 2 words with cs_n held low; buffer 0x11111111, refilled with 0x22222222 during word 1.
  - required: MISO sends 0x11111111 then 0x22222222; 2 rx_valid pulses with the correct words.
- Abort: raise cs_n after 13 bits -> no rx_valid, rx_data unchanged, MISO_oe=0; the next full transfer is received correctly.
- Same-cycle load: tx_valid asserted in the cs_n-fall detection cycle with the buffer empty -> word 1 all 0s with tx_underrun; word 2 carries the loaded value.
